// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage. Owns the fetch PC, issues in-order requests to a
//   pipelined instruction memory (req/gnt/rvalid), buffers returned words in a
//   small FIFO and presents the head to decode. An execute-stage redirect
//   squashes the FIFO and marks every in-flight response for discard.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   imem_req_o/addr_o   fetch request and its address (the fetch PC)
//   imem_gnt_i          memory accepted the request this cycle
//   imem_rvalid_i/rdata in-order response and instruction word
//   StallD              decode holds the current head entry
//   RedirectE/PCTargetE execute-stage redirect and its target
//   InstrD/PCD/PCPlus4D instruction to decode, its PC and PC+4 (NOP when empty)
//   ValidD              InstrD holds a real instruction
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned           FIFO_DEPTH = 2   // power of two, >= 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req_o,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  input  logic                  StallD,
  input  logic                  RedirectE,
  input  logic [DATA_WIDTH-1:0] PCTargetE,
  output logic [DATA_WIDTH-1:0] InstrD,
  output logic [DATA_WIDTH-1:0] PCD,
  output logic [DATA_WIDTH-1:0] PCPlus4D,
  output logic                  ValidD
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  localparam logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(32'h0000_0013);
  localparam logic [CNT_W-1:0]      FULL      = CNT_W'(FIFO_DEPTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0] pc;
  } entry_t;

  // Fetch PC and a flag that keeps requests off until the first edge after reset
  logic                  running;
  logic [DATA_WIDTH-1:0] pcf;

  // In-order queue of PCs for granted requests awaiting their response
  logic [DATA_WIDTH-1:0] pcq [FIFO_DEPTH];
  logic [PTR_W-1:0]      pcq_wr, pcq_rd;
  logic [CNT_W-1:0]      outstanding;
  logic [CNT_W-1:0]      discard;

  // Instruction buffer
  entry_t                fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]      fifo_wr, fifo_rd;
  logic [CNT_W-1:0]      occ;

  logic                  pop, push, fire;
  logic [SUM_W-1:0]      in_use;
  logic [DATA_WIDTH-1:0] target_aligned;

  assign target_aligned = PCTargetE & ~DATA_WIDTH'(3);

  assign ValidD = (occ != '0);
  assign pop    = ValidD && !StallD;

  // Credit: buffered entries plus in-flight requests (less what leaves this
  // cycle) may never exceed the buffer depth, so the FIFO cannot overflow.
  assign in_use     = SUM_W'(occ) + SUM_W'(outstanding) - SUM_W'(pop);
  assign imem_req_o = running && !RedirectE && (in_use < SUM_W'(FIFO_DEPTH));
  assign imem_addr_o = pcf;
  assign fire        = imem_req_o && imem_gnt_i;

  // Squashed responses are consumed from the PC queue but never buffered.
  assign push = imem_rvalid_i && (discard == '0) && !RedirectE;

  assign InstrD   = ValidD ? fifo[fifo_rd].instr : NOP_INSTR;
  assign PCD      = ValidD ? fifo[fifo_rd].pc    : '0;
  assign PCPlus4D = PCD + DATA_WIDTH'(4);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running     <= 1'b0;
      pcf         <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      pcq_wr      <= '0;
      pcq_rd      <= '0;
      fifo_wr     <= '0;
      fifo_rd     <= '0;
      occ         <= '0;
    end else begin
      running <= 1'b1;

      if (fire && !imem_rvalid_i)      outstanding <= outstanding + CNT_W'(1);
      else if (!fire && imem_rvalid_i) outstanding <= outstanding - CNT_W'(1);

      if (fire)          pcq_wr <= pcq_wr + PTR_W'(1);
      if (imem_rvalid_i) pcq_rd <= pcq_rd + PTR_W'(1);

      if (RedirectE) begin
        pcf     <= target_aligned;
        // Every response still in flight after this edge is stale. Earlier
        // pending discards are part of outstanding, so they are kept.
        discard <= outstanding - CNT_W'(imem_rvalid_i);
        occ     <= '0;
        fifo_rd <= fifo_wr;
      end else begin
        if (fire) pcf <= pcf + DATA_WIDTH'(4);
        if (imem_rvalid_i && (discard != '0)) discard <= discard - CNT_W'(1);
        if (push) fifo_wr <= fifo_wr + PTR_W'(1);
        if (pop)  fifo_rd <= fifo_rd + PTR_W'(1);
        if (push && !pop)      occ <= occ + CNT_W'(1);
        else if (!push && pop) occ <= occ - CNT_W'(1);
      end
    end
  end

  // NOTE: storage arrays are not reset; occ and the queue pointers define which
  // entries are meaningful, so reset-free RAM-style storage is sufficient.
  always_ff @(posedge clk) begin
    if (fire) pcq[pcq_wr] <= pcf;
    if (push) fifo[fifo_wr] <= '{instr: imem_rdata_i, pc: pcq[pcq_rd]};
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (occ == FULL)))
    else $error("fetch_stage: instruction FIFO overflow");
`endif

endmodule

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Two fetch_stage instances share all control inputs: one from PC 0, one from
//   0xFFFF_FFF8 to exercise address wrap. A memory model answers every granted
//   request in order with instr = 0x1000 + addr after a programmable latency.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam int          DEPTH   = 2;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        gnt, rvalid, stall, redirect;
  logic [31:0] rdata, rdata_w, target;

  logic        req, valid, req_w, valid_w;
  logic [31:0] addr, instr, pcd, plus4;
  logic [31:0] addr_w, instr_w, pcd_w, plus4_w;

  fetch_stage #(.DATA_WIDTH(32), .RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .StallD(stall), .RedirectE(redirect), .PCTargetE(target),
    .InstrD(instr), .PCD(pcd), .PCPlus4D(plus4), .ValidD(valid)
  );

  fetch_stage #(.DATA_WIDTH(32), .RESET_PC(WRAP_PC), .FIFO_DEPTH(DEPTH)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req_o(req_w), .imem_addr_o(addr_w), .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata_w),
    .StallD(stall), .RedirectE(redirect), .PCTargetE(target),
    .InstrD(instr_w), .PCD(pcd_w), .PCPlus4D(plus4_w), .ValidD(valid_w)
  );

  // Memory model: pending responses, returned in order, one per cycle
  typedef struct {
    logic [31:0] addr;
    logic [31:0] waddr;
    int          due;
  } resp_t;

  resp_t pend[$];
  int    cyc, last_due, lat_min, lat_max, gnt_pct;
  logic  resp_now;
  int    total = 0;
  int    bad   = 0;

  typedef struct {
    logic        stall;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pcd;
  } vec_t;

  vec_t        tbl [14];
  logic        st, rd, found;
  logic [31:0] tg, wpc, exp_req, exp_dec;
  int          pops;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle's inputs (called at the falling edge), then let them settle.
  task automatic apply(input logic s, input logic r, input logic [31:0] t);
    stall    = s;
    redirect = r;
    target   = t;
    gnt      = (int'($urandom_range(99)) < gnt_pct);
    resp_now = (pend.size() > 0) && (pend[0].due <= cyc);
    rvalid   = resp_now;
    if (resp_now) begin
      rdata   = 32'h1000 + pend[0].addr;
      rdata_w = 32'h1000 + pend[0].waddr;
    end else begin
      rdata   = $urandom;
      rdata_w = $urandom;
    end
    #1;
  endtask

  // Record this cycle's memory traffic and move to the next falling edge.
  task automatic advance();
    resp_t r;
    int    lat;
    if (resp_now) void'(pend.pop_front());
    if (req && gnt) begin
      lat     = int'($urandom_range(lat_max, lat_min));
      r.addr  = addr;
      r.waddr = addr_w;
      r.due   = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
      last_due = r.due;
      pend.push_back(r);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    stall = 1'b0; redirect = 1'b0; target = '0;
    gnt = 1'b0; rvalid = 1'b0; rdata = '0; rdata_w = '0;
    pend.delete();
    resp_now = 1'b0;
    last_due = -1;
    #1;
    check("rst_req",    32'(req),    32'd0);
    check("rst_req_w",  32'(req_w),  32'd0);
    check("rst_valid",  32'(valid),  32'd0);
    check("rst_instr",  instr,       NOP);
    check("rst_pcd",    pcd,         32'd0);
    check("rst_plus4",  plus4,       32'd4);
    check("rst_addr",   addr,        32'd0);
    check("rst_addr_w", addr_w,      WRAP_PC);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Free-run and stall expectations, cycle 0 = first cycle out of reset
    tbl[0]  = '{1'b0, 1'b0, 32'd0,  1'b0, 32'd0};
    tbl[1]  = '{1'b0, 1'b1, 32'd0,  1'b0, 32'd0};
    tbl[2]  = '{1'b0, 1'b1, 32'd4,  1'b0, 32'd0};
    tbl[3]  = '{1'b0, 1'b1, 32'd8,  1'b1, 32'd0};
    tbl[4]  = '{1'b0, 1'b1, 32'd12, 1'b1, 32'd4};
    for (int k = 5; k <= 9; k++) tbl[k] = '{1'b1, 1'b0, 32'd0, 1'b1, 32'd8};
    tbl[10] = '{1'b0, 1'b1, 32'd16, 1'b1, 32'd8};
    tbl[11] = '{1'b0, 1'b1, 32'd20, 1'b1, 32'd12};
    tbl[12] = '{1'b0, 1'b1, 32'd24, 1'b1, 32'd16};
    tbl[13] = '{1'b0, 1'b1, 32'd28, 1'b1, 32'd20};

    gnt_pct = 100; lat_min = 1; lat_max = 1;
    #2;
    do_reset();

    for (int k = 0; k < 14; k++) begin
      apply(tbl[k].stall, 1'b0, 32'd0);
      check($sformatf("tbl%0d_req", k), 32'(req), 32'(tbl[k].exp_req));
      if (tbl[k].exp_req) check($sformatf("tbl%0d_addr", k), addr, tbl[k].exp_addr);
      check($sformatf("tbl%0d_valid", k), 32'(valid), 32'(tbl[k].exp_valid));
      if (tbl[k].exp_valid) begin
        wpc = tbl[k].exp_pcd + WRAP_PC;
        check($sformatf("tbl%0d_pcd", k),     pcd,     tbl[k].exp_pcd);
        check($sformatf("tbl%0d_instr", k),   instr,   32'h1000 + tbl[k].exp_pcd);
        check($sformatf("tbl%0d_plus4", k),   plus4,   tbl[k].exp_pcd + 32'd4);
        check($sformatf("tbl%0d_pcd_w", k),   pcd_w,   wpc);
        check($sformatf("tbl%0d_instr_w", k), instr_w, 32'h1000 + wpc);
        check($sformatf("tbl%0d_plus4_w", k), plus4_w, wpc + 32'd4);
      end else begin
        check($sformatf("tbl%0d_nop", k),     instr,   NOP);
        check($sformatf("tbl%0d_pcd0", k),    pcd,     32'd0);
        check($sformatf("tbl%0d_plus4_4", k), plus4,   32'd4);
      end
      advance();
    end

    // Redirect with a response arriving in the redirect cycle
    apply(1'b0, 1'b1, 32'h200);
    check("A_req_in_redirect", 32'(req), 32'd0);
    advance();
    apply(1'b0, 1'b0, 32'd0);
    check("A_r1_valid", 32'(valid), 32'd0);
    check("A_r1_nop",   instr,      NOP);
    check("A_r1_req",   32'(req),   32'd1);
    check("A_r1_addr",  addr,       32'h200);
    advance();
    apply(1'b0, 1'b0, 32'd0);
    check("A_r2_valid", 32'(valid), 32'd0);
    advance();
    apply(1'b0, 1'b0, 32'd0);
    check("A_r3_valid", 32'(valid), 32'd1);
    check("A_r3_pcd",   pcd,        32'h200);
    check("A_r3_instr", instr,      32'h1200);
    advance();

    // Redirect with two slow responses still in flight: both must be dropped
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 30 && pend.size() < 2; i++) begin
      apply(1'b0, 1'b0, 32'd0);
      advance();
    end
    apply(1'b0, 1'b1, 32'h300);
    check("B_req_in_redirect", 32'(req), 32'd0);
    advance();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      apply(1'b0, 1'b0, 32'd0);
      if (valid) begin
        check("B_first_pcd",   pcd,   32'h300);
        check("B_first_instr", instr, 32'h1300);
        found = 1'b1;
      end
      advance();
    end
    check("B_timeout", 32'(found), 32'd1);

    // Unaligned redirect while stalled with a full buffer
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 6; i++) begin
      apply(1'b1, 1'b0, 32'd0);
      advance();
    end
    apply(1'b1, 1'b0, 32'd0);
    check("C_full_no_req", 32'(req),   32'd0);
    check("C_full_valid",  32'(valid), 32'd1);
    advance();
    apply(1'b1, 1'b1, 32'h203);
    check("C_req_in_redirect", 32'(req), 32'd0);
    advance();
    apply(1'b1, 1'b0, 32'd0);
    check("C_flushed", 32'(valid), 32'd0);
    check("C_req",     32'(req),   32'd1);
    check("C_addr",    addr,       32'h200);
    advance();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      apply(1'b0, 1'b0, 32'd0);
      if (valid) begin
        check("C_first_pcd",   pcd,   32'h200);
        check("C_first_instr", instr, 32'h1200);
        found = 1'b1;
      end
      advance();
    end
    check("C_timeout", 32'(found), 32'd1);

    // Reset with requests in flight, then randomized back-pressure
    do_reset();
    gnt_pct = 60; lat_min = 1; lat_max = 3;
    exp_req = 32'd0;
    exp_dec = 32'd0;
    pops    = 0;
    for (int i = 0; i < 800; i++) begin
      st = (int'($urandom_range(99)) < 30);
      rd = (int'($urandom_range(99)) < 3);
      tg = $urandom;
      apply(st, rd, tg);
      if (rd)       check("rnd_no_req_on_redirect", 32'(req), 32'd0);
      else if (req) check("rnd_addr", addr, exp_req);
      check("rnd_plus4", plus4, pcd + 32'd4);
      check("rnd_credit", 32'(pend.size() <= DEPTH), 32'd1);
      if (valid) begin
        check("rnd_pcd",   pcd,   exp_dec);
        check("rnd_instr", instr, 32'h1000 + exp_dec);
      end else begin
        check("rnd_bubble", instr, NOP);
      end
      if (rd) begin
        exp_req = tg & ~32'd3;
        exp_dec = tg & ~32'd3;
      end else begin
        if (req && gnt)   exp_req = exp_req + 32'd4;
        if (valid && !st) begin
          exp_dec = exp_dec + 32'd4;
          pops++;
        end
      end
      advance();
    end
    check("rnd_progress", 32'(pops >= 50), 32'd1);

    do_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
